// File: rtl/oam_dma.sv
// OAM DMA engine: copies LENGTH bytes from a source page to DST_BASE over the
// shared bus, fencing CPU accesses to the HRAM window while the copy is running.
module oam_dma #(
  parameter logic [15:0] REG_ADDR  = 16'hFF46,
  parameter logic [15:0] DST_BASE  = 16'hFE00,
  parameter int unsigned LENGTH    = 160,
  parameter logic [15:0] HRAM_BASE = 16'hFF80,
  parameter logic [15:0] HRAM_LAST = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_w,
  input  logic        cpu_we,
  output logic [7:0]  cpu_data_r,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_w,
  output logic        bus_we,
  input  logic [7:0]  bus_data_r,
  output logic        dma_active
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_WRITE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t      state_q, state_d;
  logic [7:0]  src_hi_q, src_hi_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  latch_q, latch_d;

  logic        reg_hit, reg_wr, busy, hram_hit, granted;
  logic [7:0]  eff_hi;
  logic [15:0] dma_addr;

  assign reg_hit = (cpu_addr == REG_ADDR);
  assign reg_wr  = cpu_we && reg_hit;
  assign busy    = (state_q == S_READ) || (state_q == S_WRITE);

  // Sources in the E0..FF pages alias down to C0..DF (echo RAM mirror).
  assign eff_hi   = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;
  assign dma_addr = (state_q == S_READ) ? {eff_hi, idx_q} : (DST_BASE + {8'h00, idx_q});

  assign hram_hit = (cpu_addr >= HRAM_BASE) && (cpu_addr <= HRAM_LAST);
  assign granted  = hram_hit && (cpu_addr == dma_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      src_hi_q <= 8'hFF;
      idx_q    <= '0;
      latch_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_hi_q <= src_hi_d;
      idx_q    <= idx_d;
      latch_q  <= latch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    idx_d    = idx_q;
    latch_d  = latch_q;
    unique case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_START: state_d = S_READ;
      S_READ: begin
        latch_d = bus_data_r;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A register write restarts from any state, including the final WRITE.
    if (reg_wr) begin
      src_hi_d = cpu_data_w;
      idx_d    = '0;
      state_d  = S_START;
    end
  end

  always_comb begin
    bus_addr   = cpu_addr;
    bus_data_w = cpu_data_w;
    bus_we     = cpu_we && !reg_hit;
    if (busy) begin
      bus_addr   = dma_addr;
      bus_data_w = latch_q;
      bus_we     = (state_q == S_WRITE);
    end
  end

  always_comb begin
    cpu_data_r = bus_data_r;
    if (reg_hit) begin
      cpu_data_r = src_hi_q;
    end else if (busy && !granted) begin
      cpu_data_r = 8'hFF;
    end
  end

  assign dma_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a flat 64 KiB memory sits on the shared bus; DMA writes are
// scoreboarded against expected {addr,data} pairs queued when each transfer is launched.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_w;
  logic        cpu_we;
  logic [7:0]  cpu_data_r;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_w;
  logic        bus_we;
  logic [7:0]  bus_data_r;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  logic [23:0] sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cnt   = 0;

  always #5 clk = ~clk;

  oam_dma #(
    .REG_ADDR (16'hFF46),
    .DST_BASE (16'hFE00),
    .LENGTH   (160),
    .HRAM_BASE(16'hFF80),
    .HRAM_LAST(16'hFFFE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_data_w(cpu_data_w),
    .cpu_we    (cpu_we),
    .cpu_data_r(cpu_data_r),
    .bus_addr  (bus_addr),
    .bus_data_w(bus_data_w),
    .bus_we    (bus_we),
    .bus_data_r(bus_data_r),
    .dma_active(dma_active)
  );

  assign bus_data_r = mem[bus_addr];
  always @(posedge clk) if (bus_we) mem[bus_addr] <= bus_data_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every DMA bus write must match the oldest expected entry.
  always @(negedge clk) begin
    if (dma_active && bus_we) begin
      if (sb_q.size() == 0) check("sb_underflow", {8'h00, bus_addr, bus_data_w}, 32'h0);
      else check("dma_wr", {8'h00, bus_addr, bus_data_w}, {8'h00, sb_q.pop_front()});
      wr_cnt++;
    end
  end

  function automatic logic [7:0] pat(input logic [7:0] page, input int unsigned i);
    logic [7:0] b;
    b = 8'(i);
    return (page == 8'hC0) ? b : (8'hFF - b);
  endfunction

  task automatic push_page(input logic [7:0] page, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) sb_q.push_back({16'hFE00 + 16'(i), pat(page, i)});
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data_w = d; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  task automatic cpu_rd_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
    cpu_addr = a; cpu_we = 1'b0;
    @(negedge clk);
    check(tag, {24'h0, cpu_data_r}, {24'h0, exp});
    @(posedge clk); #1;
  endtask

  task automatic reg_write(input logic [7:0] d, input bit chk_fwd);
    cpu_addr = 16'hFF46; cpu_data_w = d; cpu_we = 1'b1;
    @(negedge clk);
    if (chk_fwd) check("reg_no_fwd", {31'h0, bus_we}, 32'h0);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  // Counts active cycles from the cycle after the register write; optional mid-transfer probes.
  task automatic wait_idle(input bit probe, output int cyc);
    cyc = 0;
    for (int k = 0; k < 2000; k++) begin
      if (probe && k == 20) begin cpu_addr = 16'h8000; cpu_we = 1'b0; end
      if (probe && k == 21) cpu_addr = 16'hFF46;
      if (probe && k == 22) begin cpu_addr = 16'hC000; cpu_data_w = 8'h55; cpu_we = 1'b1; end
      if (probe && k == 24) begin cpu_addr = 16'h0000; cpu_we = 1'b0; end
      @(negedge clk);
      if (!dma_active) break;
      if (probe && k == 20) check("blocked_rd", {24'h0, cpu_data_r}, 32'hFF);
      if (probe && k == 21) check("src_rd_busy", {24'h0, cpu_data_r}, 32'hC0);
      if (probe && (k == 22 || k == 23))
        check("blocked_wr", {31'h0, (bus_we && bus_addr == 16'hC000)}, 32'h0);
      cyc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_writes(input int base, input int n);
    for (int k = 0; k < 1000; k++) begin
      if (wr_cnt - base >= n) return;
      @(posedge clk); #1;
    end
    check("wait_writes_timeout", wr_cnt - base, n);
  endtask

  task automatic readback(input string tag, input logic [7:0] page);
    for (int unsigned i = 0; i < 160; i++) cpu_rd_check(tag, 16'hFE00 + 16'(i), pat(page, i));
  endtask

  initial begin
    int cyc;
    int base;
    reset = 1'b1; cpu_addr = 16'h0000; cpu_data_w = 8'h00; cpu_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cpu_addr = 16'hFF46;
    @(negedge clk);
    check("rst_active", {31'h0, dma_active}, 32'h0);
    check("rst_src_hi", {24'h0, cpu_data_r}, 32'hFF);
    @(posedge clk); #1;

    // Idle passthrough to HRAM
    cpu_addr = 16'hFF80; cpu_data_w = 8'h3C; cpu_we = 1'b1;
    @(negedge clk);
    check("pt_we", {31'h0, bus_we}, 32'h1);
    check("pt_addr", {16'h0, bus_addr}, 32'hFF80);
    check("pt_data", {24'h0, bus_data_w}, 32'h3C);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    @(negedge clk);
    check("pt_we_low", {31'h0, bus_we}, 32'h0);
    check("pt_rd", {24'h0, cpu_data_r}, 32'h3C);
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 160; i++) begin
      cpu_wr(16'hC000 + 16'(i), pat(8'hC0, i));
      cpu_wr(16'hC100 + 16'(i), pat(8'hC1, i));
      cpu_wr(16'hE100 + 16'(i), 8'h33);
    end

    // Basic transfer with CPU probes mid-flight
    push_page(8'hC0, 160);
    reg_write(8'hC0, 1'b1);
    wait_idle(1'b1, cyc);
    check("len_c0", cyc, 321);
    check("sb_drain_c0", sb_q.size(), 0);
    readback("rb_c0", 8'hC0);
    cpu_rd_check("c000_kept", 16'hC000, 8'h00);

    // Echo mirror source
    push_page(8'hC1, 160);
    reg_write(8'hE1, 1'b1);
    wait_idle(1'b0, cyc);
    check("len_e1", cyc, 321);
    readback("rb_e1", 8'hC1);

    // Register write coinciding with the final WRITE wins
    base = wr_cnt;
    push_page(8'hC1, 160);
    reg_write(8'hC1, 1'b1);
    wait_writes(base, 159);
    @(posedge clk); #1;
    push_page(8'hC0, 160);
    reg_write(8'hC0, 1'b0);
    wait_idle(1'b0, cyc);
    check("len_last_win", cyc, 321);
    check("sb_drain_win", sb_q.size(), 0);
    readback("rb_win", 8'hC0);

    // Restart mid-transfer at idx 80
    base = wr_cnt;
    push_page(8'hC0, 160);
    reg_write(8'hC0, 1'b1);
    wait_writes(base, 80);
    sb_q.delete();
    push_page(8'hC1, 160);
    reg_write(8'hC1, 1'b1);
    wait_idle(1'b0, cyc);
    check("len_restart", cyc, 321);
    readback("rb_restart", 8'hC1);

    // Reset abort at idx 10, with a simultaneous register write that must lose
    for (int unsigned i = 0; i < 160; i++) cpu_wr(16'hFE00 + 16'(i), 8'hA5);
    base = wr_cnt;
    push_page(8'hC0, 10);
    reg_write(8'hC0, 1'b1);
    wait_writes(base, 10);
    reset = 1'b1; cpu_addr = 16'hFF46; cpu_data_w = 8'hC1; cpu_we = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("abort_active", {31'h0, dma_active}, 32'h0);
    check("abort_src_hi", {24'h0, cpu_data_r}, 32'hFF);
    @(posedge clk); #1;
    check("sb_drain_abort", sb_q.size(), 0);
    for (int unsigned i = 0; i < 160; i++)
      cpu_rd_check("rb_abort", 16'hFE00 + 16'(i), (i < 10) ? pat(8'hC0, i) : 8'hA5);
    @(negedge clk);
    check("abort_stays_idle", {31'h0, dma_active}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
